// File: rtl/sdcard_sector_buffer.sv
// rtl/sdcard_sector_buffer.sv - ping-pong 512-byte sector buffer between SD DMA port and a byte stream
//
// Purpose:
//   Captures the SD interface DMA byte stream into two RAM banks, replays each
//   completed sector in order on a valid/ready byte stream, and exposes status,
//   error flags, a sector counter and a drain enable through a small register window.
//
// Ports:
//   clk, rst                         system clock, synchronous active-high reset
//   dma_data/dma_addr/dma_strobe     incoming sector bytes with their offset
//   sram_a/sram_d_in/sram_d_out      CPU register window (only sram_a[2:0] decoded)
//   sram_cs/sram_oe/sram_we          CPU window select / read enable / write enable
//   sram_wait                        always 0
//   out_data/out_valid/out_ready     outgoing byte stream
//   out_last                         marks the final byte of each sector

module sdcard_sector_buffer #(
    parameter int SECTOR_BYTES = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dma_data,
    input  logic [8:0] dma_addr,
    input  logic       dma_strobe,
    input  logic [9:0] sram_a,
    input  logic [7:0] sram_d_in,
    output logic [7:0] sram_d_out,
    input  logic       sram_cs,
    input  logic       sram_oe,
    input  logic       sram_we,
    output logic       sram_wait,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int              AW        = $clog2(SECTOR_BYTES);
    localparam logic [8:0]      LAST_ADDR = 9'(SECTOR_BYTES - 1);
    localparam logic [AW-1:0]   LAST_PTR  = AW'(SECTOR_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_PRESENT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_mem [0:2*SECTOR_BYTES-1];
    logic [1:0]      r_full;
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [8:0]      r_expect;
    logic            r_overrun;
    logic            r_seq_err;
    logic [7:0]      r_count;
    logic            r_drain_en;
    logic [AW-1:0]   r_rd_ptr;
    logic [7:0]      r_out_data;
    logic            r_out_last;

    logic            w_reg_wr;
    logic            w_wr_status;
    logic            w_wr_count;
    logic            w_wr_ctrl;
    logic            w_flush;
    logic            w_fill;
    logic            w_drop;
    logic            w_fill_last;
    logic            w_seq_bad;
    logic            w_handshake;
    logic            w_drain_last;
    logic [1:0]      w_full_set;
    logic [1:0]      w_full_clr;
    logic [7:0]      w_rd_data;
    logic            w_unused;

    assign w_reg_wr     = sram_cs & sram_we;
    assign w_wr_status  = w_reg_wr && (sram_a[2:0] == 3'd0);
    assign w_wr_count   = w_reg_wr && (sram_a[2:0] == 3'd1);
    assign w_wr_ctrl    = w_reg_wr && (sram_a[2:0] == 3'd2);
    assign w_flush      = w_wr_status & sram_d_in[7];

    // A flush swallows a coincident strobe silently: it is neither stored nor an overrun.
    assign w_fill       = dma_strobe & ~w_flush & ~r_full[r_wr_bank];
    assign w_drop       = dma_strobe & ~w_flush &  r_full[r_wr_bank];
    assign w_fill_last  = w_fill && (dma_addr == LAST_ADDR);
    assign w_seq_bad    = w_fill && (dma_addr != r_expect);

    assign w_handshake  = (r_state == S_PRESENT) && out_ready;
    assign w_drain_last = w_handshake && r_out_last;

    // Fill only ever completes an empty bank and drain only ever frees a full one,
    // so in the same cycle these always touch different bits.
    assign w_full_set   = w_fill_last  ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr   = w_drain_last ? (2'b01 << r_rd_bank) : 2'b00;

    assign w_unused     = ^{sram_a[9:3], sram_oe, sram_d_in[6:2]};

    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_mem[{r_wr_bank, dma_addr[AW-1:0]}] <= dma_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_expect  <= 9'd0;
        end else if (w_flush) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_expect  <= 9'd0;
        end else begin
            r_full <= (r_full & ~w_full_clr) | w_full_set;
            if (w_fill_last) begin
                r_wr_bank <= ~r_wr_bank;
                r_expect  <= 9'd0;
            end else if (w_fill) begin
                r_expect  <= dma_addr + 9'd1;
            end
            if (w_drain_last) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Flags, counter and drain enable survive a flush; a set event beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun  <= 1'b0;
            r_seq_err  <= 1'b0;
            r_count    <= 8'd0;
            r_drain_en <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_wr_status && sram_d_in[0]) begin
                r_overrun <= 1'b0;
            end
            if (w_seq_bad) begin
                r_seq_err <= 1'b1;
            end else if (w_wr_status && sram_d_in[1]) begin
                r_seq_err <= 1'b0;
            end
            if (w_wr_count) begin
                r_count <= 8'd0;
            end else if (w_fill_last) begin
                r_count <= r_count + 8'd1;
            end
            if (w_wr_ctrl) begin
                r_drain_en <= sram_d_in[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // drain_en only gates starting a sector; a sector in progress always runs to its last byte.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (r_drain_en && r_full[r_rd_bank]) w_state_nxt = S_READ;
            S_READ:    w_state_nxt = S_PRESENT;
            S_PRESENT: if (out_ready) w_state_nxt = r_out_last ? S_IDLE : S_READ;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_out_data <= 8'd0;
            r_out_last <= 1'b0;
        end else if (w_flush) begin
            r_rd_ptr   <= '0;
            r_out_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_rd_ptr <= '0;
                S_READ: begin
                    r_out_data <= r_mem[{r_rd_bank, r_rd_ptr}];
                    r_out_last <= (r_rd_ptr == LAST_PTR);
                end
                S_PRESENT: if (w_handshake) r_rd_ptr <= r_rd_ptr + AW'(1);
                default: r_rd_ptr <= '0;
            endcase
        end
    end

    always_comb begin
        w_rd_data = 8'd0;
        case (sram_a[2:0])
            3'd0:    w_rd_data = {r_full[1], r_full[0], r_wr_bank, r_rd_bank, 2'b00, r_seq_err, r_overrun};
            3'd1:    w_rd_data = r_count;
            3'd2:    w_rd_data = {7'd0, r_drain_en};
            default: w_rd_data = 8'd0;
        endcase
    end

    assign sram_d_out = w_rd_data;
    assign sram_wait  = 1'b0;
    assign out_data   = r_out_data;
    assign out_valid  = (r_state == S_PRESENT);
    assign out_last   = r_out_last;

endmodule

// File: tb/tb_sdcard_sector_buffer.sv
// tb/tb_sdcard_sector_buffer.sv - scoreboard bench for sdcard_sector_buffer

module tb_sdcard_sector_buffer;

    localparam int SB = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dma_data;
    logic [8:0] dma_addr;
    logic       dma_strobe;
    logic [9:0] sram_a;
    logic [7:0] sram_d_in;
    logic [7:0] sram_d_out;
    logic       sram_cs, sram_oe, sram_we, sram_wait;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last;

    always #5 clk = ~clk;

    sdcard_sector_buffer #(.SECTOR_BYTES(SB)) dut (
        .clk(clk), .rst(rst),
        .dma_data(dma_data), .dma_addr(dma_addr), .dma_strobe(dma_strobe),
        .sram_a(sram_a), .sram_d_in(sram_d_in), .sram_d_out(sram_d_out),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we), .sram_wait(sram_wait),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_mem [2][SB];
    logic [1:0] m_full;
    logic       m_wr, m_rd, m_over, m_seq, m_drain;
    int         m_exp;
    logic [7:0] m_count;

    int n_vec = 0, n_err = 0, n_popped = 0;
    bit rand_ready = 0, skip_stab = 0, prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] status_m();
        return {m_full[1], m_full[0], m_wr, m_rd, 2'b00, m_seq, m_over};
    endfunction

    task automatic model_reset();
        q.delete();
        m_full = 2'b00; m_wr = 1'b0; m_rd = 1'b0; m_exp = 0;
        m_over = 1'b0; m_seq = 1'b0; m_count = 8'd0; m_drain = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic strobe(input logic [8:0] a, input logic [7:0] d);
        dma_addr = a; dma_data = d; dma_strobe = 1'b1;
        if (m_full[m_wr]) begin
            m_over = 1'b1;
        end else begin
            m_mem[m_wr][a] = d;
            if (int'(a) != m_exp) m_seq = 1'b1;
            if (int'(a) == SB - 1) begin
                for (int i = 0; i < SB; i++) q.push_back('{m_mem[m_wr][i], (i == SB - 1)});
                m_full[m_wr] = 1'b1;
                m_wr = ~m_wr;
                m_exp = 0;
                m_count = m_count + 8'd1;
            end else begin
                m_exp = int'(a) + 1;
            end
        end
        tick();
        dma_strobe = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int kind, input int a);
        case (kind)
            0:       return 8'(a) ^ 8'h5A;
            1:       return 8'(a) ^ 8'hA5;
            2:       return 8'(a + 3);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic fill_range(input int kind, input int lo, input int hi, input bit gaps);
        for (int a = lo; a <= hi; a++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            strobe(9'(a), pat(kind, a));
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        sram_a = {7'd0, a}; sram_d_in = d; sram_cs = 1'b1; sram_we = 1'b1;
        tick();
        sram_cs = 1'b0; sram_we = 1'b0;
        case (a)
            3'd0: begin
                if (d[0]) m_over = 1'b0;
                if (d[1]) m_seq = 1'b0;
                if (d[7]) begin
                    q.delete();
                    m_full = 2'b00; m_wr = 1'b0; m_rd = 1'b0; m_exp = 0;
                    skip_stab = 1'b1;
                end
            end
            3'd1: m_count = 8'd0;
            3'd2: m_drain = d[0];
            default: ;
        endcase
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        sram_a = {7'd0, a}; sram_cs = 1'b1; sram_oe = 1'b1;
        #1;
        check(name, 16'(sram_d_out), 16'(exp));
        sram_cs = 1'b0; sram_oe = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20000 && q.size() != 0; i++) tick();
        check(name, 16'(q.size()), 16'd0);
        tick();
        tick();
    endtask

    // Scoreboard monitor: samples mid-cycle, so a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !skip_stab)
                check("hold_stable", 16'({out_valid, out_last, out_data}), 16'({1'b1, prev_last, prev_data}));
            skip_stab = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_byte: got 0x%0h expected no byte at %0t", out_data, $time);
                end else begin
                    e = q.pop_front();
                    check("out_data", 16'(out_data), 16'(e.data));
                    check("out_last", 16'(out_last), 16'(e.last));
                    if (e.last) begin
                        m_full[m_rd] = 1'b0;
                        m_rd = ~m_rd;
                    end
                end
                n_popped++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1; dma_data = 8'd0; dma_addr = 9'd0; dma_strobe = 1'b0;
        sram_a = 10'd0; sram_d_in = 8'd0; sram_cs = 1'b0; sram_oe = 1'b0; sram_we = 1'b0;
        out_ready = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        rd_chk("reset_status", 3'd0, 8'h00);
        check("reset_valid", 16'(out_valid), 16'd0);
        check("sram_wait", 16'(sram_wait), 16'd0);

        // 1: single sector, continuous ready, latency and STATUS full0
        wr_reg(3'd2, 8'h01);
        rd_chk("ctrl_read", 3'd2, 8'h01);
        out_ready = 1'b1;
        fill_range(0, 0, SB - 1, 1'b0);
        check("lat_edge0", 16'(out_valid), 16'd0);
        rd_chk("t1_status_full", 3'd0, status_m());
        tick();
        check("lat_edge1", 16'(out_valid), 16'd0);
        tick();
        check("lat_edge2", 16'(out_valid), 16'd1);
        wait_drain("t1_drain");
        rd_chk("t1_status_done", 3'd0, status_m());

        // 2: two sectors held back, overrun, then drained in bank order
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        rd_chk("rst_status", 3'd0, 8'h00);
        rd_chk("rst_count", 3'd1, 8'h00);
        rd_chk("rst_ctrl", 3'd2, 8'h00);
        check("rst_out", 16'({out_valid, out_last, out_data}), 16'd0);
        wr_reg(3'd2, 8'h01);
        out_ready = 1'b0;
        fill_range(1, 0, SB - 1, 1'b0);
        fill_range(2, 0, SB - 1, 1'b0);
        rd_chk("t2_status_c0", 3'd0, status_m());
        rd_chk("t2_count", 3'd1, m_count);
        strobe(9'd0, 8'hEE);
        rd_chk("t2_overrun", 3'd0, status_m());
        out_ready = 1'b1;
        wait_drain("t2_drain");
        rd_chk("t2_status_after", 3'd0, status_m());
        wr_reg(3'd0, 8'h01);
        rd_chk("t2_over_clr", 3'd0, status_m());

        // 3: sequence error, byte still stored at its address
        strobe(9'd0, 8'h11);
        strobe(9'd1, 8'h22);
        strobe(9'd3, 8'h33);
        rd_chk("t3_seq_err", 3'd0, status_m());
        fill_range(3, 4, SB - 1, 1'b0);
        wait_drain("t3_drain");
        wr_reg(3'd0, 8'h02);
        rd_chk("t3_seq_clr", 3'd0, status_m());
        rd_chk("t3_count", 3'd1, m_count);
        wr_reg(3'd1, 8'h5C);
        rd_chk("t3_count_clr", 3'd1, m_count);

        // 4: random backpressure while the other bank fills
        out_ready = 1'b0;
        fill_range(3, 0, SB - 1, 1'b1);
        rand_ready = 1'b1;
        fill_range(3, 0, SB - 1, 1'b1);
        wait_drain("t4_drain");
        rand_ready = 1'b0;
        out_ready = 1'b1;
        rd_chk("t4_status", 3'd0, status_m());

        // 5: flush part-way through a sector
        out_ready = 1'b0;
        fill_range(2, 0, SB - 1, 1'b0);
        out_ready = 1'b1;
        base = n_popped;
        for (int i = 0; i < 2000 && n_popped < base + 100; i++) tick();
        check("t5_reached_100", 16'(n_popped - base), 16'd100);
        out_ready = 1'b0;
        wr_reg(3'd0, 8'h80);
        check("t5_valid_drop", 16'(out_valid), 16'd0);
        rd_chk("t5_status", 3'd0, status_m());
        tick();
        check("t5_valid_stay", 16'(out_valid), 16'd0);
        out_ready = 1'b1;
        fill_range(3, 0, SB - 1, 1'b0);
        wait_drain("t5_drain");
        rd_chk("t5_status_after", 3'd0, status_m());

        // 6: reset in the middle of a fill
        rd_chk("t6_count_pre", 3'd1, m_count);
        fill_range(1, 0, 199, 1'b0);
        dma_addr = 9'd200; dma_data = 8'h77; dma_strobe = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; dma_strobe = 1'b0;
        model_reset();
        rd_chk("t6_status", 3'd0, 8'h00);
        rd_chk("t6_count", 3'd1, 8'h00);
        rd_chk("t6_ctrl", 3'd2, 8'h00);
        check("t6_out", 16'({out_valid, out_last, out_data}), 16'd0);
        wr_reg(3'd2, 8'h01);
        fill_range(3, 0, SB - 1, 1'b0);
        wait_drain("t6_drain");
        rd_chk("t6_status_after", 3'd0, status_m());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
